// File: rtl/change_dispense_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : change_pkg
// Description : Shared types and constants for the change dispenser.
//               Holds the controller state encoding, the two coin values
//               and the default money width.
// Revision    : 1.0  initial release
// ============================================================================
package change_pkg;

    localparam int AMT_W_DEFAULT = 8;
    localparam int COIN_BIG      = 10;
    localparam int COIN_SMALL    = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ10 = 3'd2,
        S_REL10 = 3'd3,
        S_REQ5  = 3'd4,
        S_REL5  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/change_dispense_ctrl_coin_handshake.sv
`default_nettype none
// ============================================================================
// Module      : coin_handshake
// Description : One 4-phase req/ack channel toward the coin hopper.
//               go       : controller is in a request phase (req follows it)
//               rel      : controller is waiting for ack to return low
//               ack      : hopper acknowledge
//               req      : request to hopper
//               complete : ack accepted during request phase
//               released : ack observed low during release phase
//               timeout_flag : waited TIMEOUT cycles in the current phase
//               Optional macro: COIN_TIMEOUT_EN enables the wait counter.
// Revision    : 1.0  initial release
// ============================================================================
module coin_handshake #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic rel,
    input  logic ack,
    output logic req,
    output logic complete,
    output logic released,
    output logic timeout_flag
);

    // An ack only counts once it has been seen low since the previous
    // completed coin; an ack left high from an earlier handshake is stale.
    logic armed;

    always_ff @(posedge clk) begin
        if (!reset) begin
            armed <= 1'b0;
        end else begin
            armed <= ~ack | (armed & ~complete);
        end
    end

    assign req      = go;
    assign complete = go & ack & armed;
    assign released = rel & ~ack;

`ifdef COIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             waiting;
    logic [CNT_W-1:0] wait_cnt;

    // Counter restarts whenever a phase ends, so it is zero on entry to
    // both the request and the release phase.
    assign waiting = (go & ~complete) | (rel & ~released);

    always_ff @(posedge clk) begin
        if (!reset || !waiting) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_flag = waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    // Parameter stays referenced so both builds share one interface.
    assign timeout_flag = 1'b0 & (TIMEOUT == 0);
`endif

endmodule
`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_ctrl
// Description : Pays out an amount largest-coin-first (10 then 5), one coin
//               per 4-phase handshake, exporting the remaining balance.
//   Ports: clk, reset (sync, active-low), start, amount, abort, coin_ack,
//          coin10_req, coin5_req, remaining, busy, done, err.
//   Optional macro: COIN_TIMEOUT_EN -> hopper wait timeout of TIMEOUT cycles.
// Revision    : 1.0  initial release
// ============================================================================
module change_dispense_ctrl
    import change_pkg::*;
#(
    parameter int AMT_W   = AMT_W_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             abort,
    input  logic             coin_ack,
    output logic             coin10_req,
    output logic             coin5_req,
    output logic [AMT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           next_state;
    logic             abort_q;
    logic             abort_seen;
    logic             hs_go;
    logic             hs_rel;
    logic             hs_req;
    logic             hs_complete;
    logic             hs_released;
    logic             hs_timeout;
    logic             sel_big;
    logic [AMT_W-1:0] coin_val;

    assign abort_seen = abort_q | abort;
    assign coin_val   = sel_big ? AMT_W'(COIN_BIG) : AMT_W'(COIN_SMALL);

    coin_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_handshake (
        .clk          (clk),
        .reset        (reset),
        .go           (hs_go),
        .rel          (hs_rel),
        .ack          (coin_ack),
        .req          (hs_req),
        .complete     (hs_complete),
        .released     (hs_released),
        .timeout_flag (hs_timeout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_CHECK;
            end
            S_CHECK: begin
                if (abort_seen)                                    next_state = S_IDLE;
                else if ((remaining % AMT_W'(COIN_SMALL)) != '0)   next_state = S_ERR;
                else if (remaining >= AMT_W'(COIN_BIG))            next_state = S_REQ10;
                else if (remaining == AMT_W'(COIN_SMALL))          next_state = S_REQ5;
                else if (remaining == '0)                          next_state = S_DONE;
                else                                               next_state = S_ERR;
            end
            S_REQ10: begin
                if (hs_timeout)       next_state = S_IDLE;
                else if (hs_complete) next_state = S_REL10;
            end
            S_REQ5: begin
                if (hs_timeout)       next_state = S_IDLE;
                else if (hs_complete) next_state = S_REL5;
            end
            S_REL10, S_REL5: begin
                if (hs_timeout)       next_state = S_IDLE;
                else if (hs_released) next_state = abort_seen ? S_IDLE : S_CHECK;
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        hs_go      = (state == S_REQ10) || (state == S_REQ5);
        hs_rel     = (state == S_REL10) || (state == S_REL5);
        sel_big    = (state == S_REQ10) || (state == S_REL10);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        coin10_req = hs_req & sel_big;
        coin5_req  = hs_req & ~sel_big;
    end

    // Balance, sticky error and latched abort
    always_ff @(posedge clk) begin
        if (!reset) begin
            remaining <= '0;
            err       <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                remaining <= amount;
                err       <= 1'b0;
            end else if (hs_complete && (remaining >= coin_val)) begin
                remaining <= remaining - coin_val;
            end

            if ((state == S_ERR) || hs_timeout) begin
                err <= 1'b1;
            end

            if (next_state == S_IDLE) begin
                abort_q <= 1'b0;
            end else if (busy && abort) begin
                abort_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispense_ctrl
// Description : Randomised self-checking bench for change_dispense_ctrl with
//               a behavioural hopper and a payout reference model.
//               Optional macro: COIN_TIMEOUT_EN adds the timeout scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_change_dispense_ctrl;

    localparam int AMT_W = 8;
`ifdef COIN_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             abort;
    logic             coin_ack;
    logic             coin10_req;
    logic             coin5_req;
    logic [AMT_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic             err;

    int total = 0;
    int bad   = 0;

    int hop_en      = 1;
    int fixed_delay = -1;

    always #5 clk = ~clk;

    change_dispense_ctrl #(
        .AMT_W   (AMT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .abort      (abort),
        .coin_ack   (coin_ack),
        .coin10_req (coin10_req),
        .coin5_req  (coin5_req),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Hopper: raises ack some cycles after a request, drops it some cycles
    // after the request goes away.
    initial begin : hopper
        int hs;
        int hc;
        int hd;
        hs = 0; hc = 0; hd = -1;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                hs = 0; hc = 0; hd = -1;
                coin_ack = 1'b0;
            end else begin
                case (hs)
                    0: if (hop_en != 0 && (coin10_req || coin5_req)) begin
                        if (hd < 0) hd = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(1, 4));
                        if (hc >= hd) begin
                            coin_ack = 1'b1; hs = 1; hc = 0; hd = -1;
                        end else begin
                            hc++;
                        end
                    end
                    1: if (!coin10_req && !coin5_req) begin
                        hs = 2; hc = 0; hd = int'($urandom_range(0, 3));
                    end
                    default: if (hc >= hd) begin
                        coin_ack = 1'b0; hs = 0; hc = 0; hd = -1;
                    end else begin
                        hc++;
                    end
                endcase
            end
        end
    end

    // Total coins the greedy rule uses for a valid amount.
    function automatic int coin_count(input int amt);
        return amt / 10 + (amt % 10) / 5;
    endfunction

    // One payout: abort_at>0 pulses abort when that coin's request rises;
    // repulse re-fires start with amount=50 while busy.
    task automatic pay(input int amt, input int abort_at, input bit repulse);
        int bal, n10, n5, ndone, done_cyc, nbusy, first_req, cyc;
        int ebal, e10, e5, k;
        bit p10, p5, overlap;

        // Reference model: greedy payout stopping after abort_at coins.
        ebal = amt; e10 = 0; e5 = 0; k = 0;
        if (amt % 5 == 0) begin
            while (ebal > 0 && !(abort_at > 0 && k == abort_at)) begin
                if (ebal >= 10) begin ebal -= 10; e10++; end
                else            begin ebal -= 5;  e5++;  end
                k++;
            end
        end

        bal = amt; n10 = 0; n5 = 0; ndone = 0; done_cyc = -1; nbusy = 0;
        first_req = -1; p10 = 1'b0; p5 = 1'b0; overlap = 1'b0;

        @(negedge clk);
        amount = AMT_W'(amt);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        amount = AMT_W'($urandom);

        for (cyc = 1; cyc < 3000; cyc++) begin
            if (cyc > 1) @(negedge clk);
            abort = 1'b0;
            if (busy) nbusy++;
            if (done) begin ndone++; done_cyc = cyc; end
            if (coin10_req && coin5_req) overlap = 1'b1;
            if (coin10_req && !p10) begin
                n10++;
                if (first_req < 0) first_req = cyc;
                check_eq("bal_at_req10", int'(remaining), bal);
                check_eq("req10_allowed", int'(bal >= 10), 1);
                if (n10 + n5 == abort_at) abort = 1'b1;
            end
            if (!coin10_req && p10) begin
                bal -= 10;
                check_eq("bal_after10", int'(remaining), bal);
            end
            if (coin5_req && !p5) begin
                n5++;
                if (first_req < 0) first_req = cyc;
                check_eq("bal_at_req5", int'(remaining), bal);
                check_eq("req5_allowed", int'(bal == 5), 1);
                if (n10 + n5 == abort_at) abort = 1'b1;
            end
            if (!coin5_req && p5) begin
                bal -= 5;
                check_eq("bal_after5", int'(remaining), bal);
            end
            p10 = coin10_req;
            p5  = coin5_req;
            start = repulse && (cyc == 4);
            if (start) amount = 8'd50;
            if (!busy) break;
        end
        start = 1'b0;
        abort = 1'b0;

        check_eq("txn_bounded", int'(cyc < 3000), 1);
        check_eq("n_coin10", n10, e10);
        check_eq("n_coin5", n5, e5);
        check_eq("remaining_end", int'(remaining), ebal);
        check_eq("err_end", int'(err), int'(amt % 5 != 0));
        check_eq("done_pulses", ndone, int'(amt % 5 == 0 && abort_at <= 0));
        check_eq("req_overlap", int'(overlap), 0);
        if (amt == 0) begin
            check_eq("zero_done_cyc", done_cyc, 2);
            check_eq("zero_busy_cycles", nbusy, 2);
        end
        if (amt % 5 != 0) check_eq("err_busy_cycles", nbusy, 2);
        if (amt % 5 == 0 && amt > 0 && abort_at != 1) check_eq("req_latency", first_req, 2);
    endtask

    initial begin : main
        int amt, tc, ab, hi;
        reset = 1'b0; start = 1'b0; abort = 1'b0; amount = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_remaining", int'(remaining), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_reqs", int'({coin10_req, coin5_req}), 0);
        check_eq("rst_done_err", int'({done, err}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed scenarios
        fixed_delay = 3;
        pay(35, 0, 1'b0);
        fixed_delay = -1;
        pay(0, 0, 1'b0);
        pay(12, 0, 1'b0);
        pay(5, 0, 1'b0);
        pay(30, 2, 1'b0);
        pay(40, 0, 1'b1);

        // Randomised payouts
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 5) == 0) amt = int'($urandom_range(1, 60));
            else                            amt = int'($urandom_range(0, 14)) * 5;
            tc = (amt % 5 == 0) ? coin_count(amt) : 0;
            ab = (tc > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, tc)) : 0;
            pay(amt, ab, ($urandom_range(0, 4) == 0));
        end

        // Reset while a 10-coin request is pending
        hop_en = 0;
        @(negedge clk);
        amount = 8'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !coin10_req; c++) @(negedge clk);
        check_eq("rst_mid_req_seen", int'(coin10_req), 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_outputs", int'({coin10_req, coin5_req, busy, done, err}), 0);
        check_eq("rst_mid_remaining", int'(remaining), 0);
        reset = 1'b1;
        hop_en = 1;
        repeat (6) @(negedge clk);
        pay(15, 0, 1'b0);

`ifdef COIN_TIMEOUT_EN
        // Hopper never answers: request must drop after TMO cycles
        hop_en = 0;
        @(negedge clk);
        amount = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi = 0;
        for (int c = 0; c < 200 && (busy || c == 0); c++) begin
            if (coin10_req) hi++;
            @(negedge clk);
        end
        check_eq("tmo_req_cycles", hi, TMO);
        check_eq("tmo_err", int'(err), 1);
        check_eq("tmo_remaining", int'(remaining), 20);
        check_eq("tmo_idle", int'(busy), 0);
        hop_en = 1;
        repeat (6) @(negedge clk);
        pay(25, 0, 1'b0);
`else
        hi = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
